store_req_unit: RTL and testbench

- Store-side counterpart of the MEM-stage load path: receives store operations (sw/sb/sh/swl/swr) from the EX stage.
- Produces byte-aligned write data and byte strobes for each store.
- Issues stores to the data SRAM-like interface with a req/addr_ok/data_ok handshake.
- Tracks outstanding writes so the pipeline can drain them before exception or eret flushes.

---
 rtl/store_req_unit_pkg.sv | 18 +
 rtl/store_align.sv | 40 ++++
 rtl/store_req_unit.sv | 63 ++++++
 tb/tb_store_req_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_req_unit_pkg.sv
// store_req_unit_pkg: store op bit positions, size encodings and the aligned request record.
package store_req_unit_pkg;
  localparam int ST_OP_WD = 5;
  localparam int ST_SW  = 4;
  localparam int ST_SB  = 3;
  localparam int ST_SH  = 2;
  localparam int ST_SWL = 1;
  localparam int ST_SWR = 0;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } st_req_t;
endpackage

// File: rtl/store_align.sv
// store_align: turns a store op, address and rt value into byte-aligned addr/size/strobe/data.
module store_align
  import store_req_unit_pkg::*;
(
  input  logic [ST_OP_WD-1:0] st_op,
  input  logic [31:0]         st_addr,
  input  logic [31:0]         st_data,
  output st_req_t             req
);
  logic [1:0] a;
  assign a = st_addr[1:0];
  always_comb begin
    req = '0;
    req.addr = st_addr;
    if (st_op[ST_SW]) begin
      req.addr  = {st_addr[31:2], 2'b00};
      req.size  = SZ_WORD;
      req.wstrb = 4'b1111;
      req.wdata = st_data;
    end else if (st_op[ST_SB]) begin
      req.size  = SZ_BYTE;
      req.wstrb = 4'b0001 << a;
      req.wdata = {4{st_data[7:0]}};
    end else if (st_op[ST_SH]) begin
      req.size  = SZ_HALF;
      req.wstrb = a[1] ? 4'b1100 : 4'b0011;
      req.wdata = {2{st_data[15:0]}};
    end else if (st_op[ST_SWL]) begin
      // swl writes the top (a+1) bytes of rt into the low end of the word
      req.addr  = {st_addr[31:2], 2'b00};
      req.size  = a == 2'd0 ? SZ_BYTE : a == 2'd1 ? SZ_HALF : SZ_WORD;
      req.wstrb = 4'b1111 >> ~a;
      req.wdata = st_data >> {~a, 3'b000};
    end else if (st_op[ST_SWR]) begin
      req.size  = a == 2'd3 ? SZ_BYTE : a == 2'd2 ? SZ_HALF : SZ_WORD;
      req.wstrb = 4'b1111 << a;
      req.wdata = st_data << {a, 3'b000};
    end
  end
endmodule

// File: rtl/store_req_unit.sv
// store_req_unit: holds one aligned store request for the data bus and counts issued-but-incomplete writes.
module store_req_unit
  import store_req_unit_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [ST_OP_WD-1:0] st_op,
  input  logic [31:0]         st_addr,
  input  logic [31:0]         st_data,
  input  logic                flush,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [31:0]         data_addr,
  output logic [3:0]          data_wstrb,
  output logic [31:0]         data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  output logic                st_done,
  output logic                st_idle
);
  st_req_t          req_d, req_q;
  logic             req_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             accept, issue;

  store_align u_align (.st_op(st_op), .st_addr(st_addr), .st_data(st_data), .req(req_d));

  assign st_ready   = !req_valid_q && cnt_q < CNT_W'(MAX_OUTST) && !flush;
  assign accept     = st_valid && st_ready;
  assign issue      = req_valid_q && data_addr_ok;
  assign st_done    = data_data_ok && cnt_q != '0;
  assign cnt_d      = cnt_q + CNT_W'(issue) - CNT_W'(st_done);
  assign st_idle    = !req_valid_q && cnt_q == '0;
  assign data_req   = req_valid_q;
  assign data_wr    = req_valid_q;
  assign data_addr  = req_q.addr;
  assign data_size  = req_q.size;
  assign data_wstrb = req_q.wstrb;
  assign data_wdata = req_q.wdata;

  // a flush drops a held request unless memory takes it in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_valid_q <= 1'b0;
      req_q       <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        req_valid_q <= 1'b1;
        req_q       <= req_d;
      end else if (issue || flush) begin
        req_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_store_req_unit.sv
// tb_store_req_unit: directed scenario tasks with hand-computed expectations for store_req_unit.
module tb_store_req_unit;
  logic        clk = 1'b0;
  logic        resetn, st_valid, flush, data_addr_ok, data_data_ok;
  logic        st_ready, data_req, data_wr, st_done, st_idle;
  logic [4:0]  st_op;
  logic [31:0] st_addr, st_data, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  int n_tests = 0;
  int n_fail = 0;

  localparam logic [4:0] OP_SW = 5'b10000, OP_SB = 5'b01000, OP_SH = 5'b00100,
                         OP_SWL = 5'b00010, OP_SWR = 5'b00001;

  store_req_unit dut (
    .clk(clk), .resetn(resetn), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .flush(flush), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .st_done(st_done), .st_idle(st_idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_store(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data);
    int waited = 0;
    while (!st_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!st_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_wait: st_ready=%b required 1 within 20 cycles", st_ready);
    end
    st_valid = 1'b1; st_op = op; st_addr = addr; st_data = data;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic pulse_addr_ok();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
  endtask

  task automatic pulse_data_ok();
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
  endtask

  task automatic check_req(input string name, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [1:0] size);
    n_tests++;
    if ({data_req, data_wr, data_addr, data_wstrb, data_wdata, data_size} !== {2'b11, addr, strb, wdata, size}) begin
      n_fail++;
      $display("FAIL %s: req=%b wr=%b addr=%h strb=%b wdata=%h size=%0d required req=1 wr=1 addr=%h strb=%b wdata=%h size=%0d",
               name, data_req, data_wr, data_addr, data_wstrb, data_wdata, data_size, addr, strb, wdata, size);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({data_req, st_done, st_idle, st_ready} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset: req/done/idle/ready=%b required 0011", {data_req, st_done, st_idle, st_ready});
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_sb();
    issue_store(OP_SB, 32'h0000_1003, 32'h0000_00AB);
    check_req("sb_fields", 32'h0000_1003, 4'b1000, 32'hABAB_ABAB, 2'd0);
    n_tests++;
    if (st_ready !== 1'b0) begin n_fail++; $display("FAIL sb_ready_held: st_ready=%b required 0", st_ready); end
    pulse_addr_ok();
    n_tests++;
    if ({data_req, st_idle} !== 2'b00) begin n_fail++; $display("FAIL sb_issued: req/idle=%b required 00", {data_req, st_idle}); end
    data_data_ok = 1'b1;
    #1;
    n_tests++;
    if (st_done !== 1'b1) begin n_fail++; $display("FAIL sb_done: st_done=%b required 1", st_done); end
    tick();
    data_data_ok = 1'b0;
    n_tests++;
    if ({st_done, st_idle} !== 2'b01) begin n_fail++; $display("FAIL sb_drained: done/idle=%b required 01", {st_done, st_idle}); end
  endtask

  task automatic test_swl_swr();
    issue_store(OP_SWL, 32'h0000_2001, 32'h1122_3344);
    check_req("swl_a1", 32'h0000_2000, 4'b0011, 32'h0000_1122, 2'd1);
    pulse_addr_ok(); pulse_data_ok();
    issue_store(OP_SWR, 32'h0000_2001, 32'h1122_3344);
    check_req("swr_a1", 32'h0000_2001, 4'b1110, 32'h2233_4400, 2'd2);
    pulse_addr_ok(); pulse_data_ok();
    issue_store(OP_SWL, 32'h0000_2002, 32'h1122_3344);
    check_req("swl_a2", 32'h0000_2000, 4'b0111, 32'h0011_2233, 2'd2);
    pulse_addr_ok(); pulse_data_ok();
    issue_store(OP_SWR, 32'h0000_2003, 32'h1122_3344);
    check_req("swr_a3", 32'h0000_2003, 4'b1000, 32'h4400_0000, 2'd0);
    pulse_addr_ok(); pulse_data_ok();
  endtask

  task automatic test_sh_null();
    issue_store(OP_SH, 32'h0000_4002, 32'hCAFE_5678);
    check_req("sh_a2", 32'h0000_4002, 4'b1100, 32'h5678_5678, 2'd1);
    pulse_addr_ok(); pulse_data_ok();
    issue_store(5'b00000, 32'h0000_5000, 32'h1234_5678);
    n_tests++;
    if ({data_req, data_wstrb} !== 5'b1_0000) begin
      n_fail++; $display("FAIL null_op: req=%b strb=%b required req=1 strb=0000", data_req, data_wstrb);
    end
    pulse_addr_ok(); pulse_data_ok();
  endtask

  task automatic test_addr_wait();
    issue_store(OP_SW, 32'h0000_3000, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      check_req("wait_stable", 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 2'd2);
      n_tests++;
      if (st_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready: cycle %0d st_ready=%b required 0", i, st_ready); end
      tick();
    end
    pulse_addr_ok();
    tick();
    n_tests++;
    if ({data_req, st_idle} !== 2'b00) begin n_fail++; $display("FAIL wait_once: req/idle=%b required 00", {data_req, st_idle}); end
    pulse_data_ok();
    n_tests++;
    if (st_idle !== 1'b1) begin n_fail++; $display("FAIL wait_drain: st_idle=%b required 1", st_idle); end
  endtask

  task automatic test_outstanding();
    issue_store(OP_SW, 32'h0000_6000, 32'h1);
    pulse_addr_ok();
    issue_store(OP_SW, 32'h0000_6004, 32'h2);
    pulse_addr_ok();
    n_tests++;
    if ({st_ready, st_idle, data_req} !== 3'b000) begin
      n_fail++; $display("FAIL outst_full: ready/idle/req=%b required 000", {st_ready, st_idle, data_req});
    end
    st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h0000_6008; st_data = 32'h3;
    tick(); tick();
    n_tests++;
    if (data_req !== 1'b0) begin n_fail++; $display("FAIL outst_stall: data_req=%b required 0", data_req); end
    data_data_ok = 1'b1;
    #1;
    n_tests++;
    if ({st_done, st_ready} !== 2'b10) begin n_fail++; $display("FAIL outst_first_done: done/ready=%b required 10", {st_done, st_ready}); end
    tick();
    data_data_ok = 1'b0;
    n_tests++;
    if (st_ready !== 1'b1) begin n_fail++; $display("FAIL outst_reopen: st_ready=%b required 1", st_ready); end
    tick();
    st_valid = 1'b0;
    check_req("outst_third", 32'h0000_6008, 4'b1111, 32'h3, 2'd2);
    pulse_addr_ok(); pulse_data_ok(); pulse_data_ok();
    n_tests++;
    if (st_idle !== 1'b1) begin n_fail++; $display("FAIL outst_drain: st_idle=%b required 1", st_idle); end
  endtask

  task automatic test_flush();
    issue_store(OP_SW, 32'h0000_7000, 32'h7);
    flush = 1'b1;
    #1;
    n_tests++;
    if (st_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: st_ready=%b required 0", st_ready); end
    tick();
    flush = 1'b0;
    n_tests++;
    if ({data_req, st_idle} !== 2'b01) begin n_fail++; $display("FAIL flush_drop: req/idle=%b required 01", {data_req, st_idle}); end
    issue_store(OP_SW, 32'h0000_7004, 32'h8);
    flush = 1'b1; data_addr_ok = 1'b1;
    tick();
    flush = 1'b0; data_addr_ok = 1'b0;
    n_tests++;
    if ({data_req, st_idle} !== 2'b00) begin n_fail++; $display("FAIL flush_issued: req/idle=%b required 00", {data_req, st_idle}); end
    data_data_ok = 1'b1;
    #1;
    n_tests++;
    if (st_done !== 1'b1) begin n_fail++; $display("FAIL flush_done: st_done=%b required 1", st_done); end
    tick();
    data_data_ok = 1'b0;
    n_tests++;
    if (st_idle !== 1'b1) begin n_fail++; $display("FAIL flush_idle: st_idle=%b required 1", st_idle); end
  endtask

  task automatic test_async_reset();
    issue_store(OP_SW, 32'h0000_8000, 32'h9);
    pulse_addr_ok();
    issue_store(OP_SW, 32'h0000_8004, 32'hA);
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({data_req, st_idle, st_ready} !== 3'b011) begin
      n_fail++; $display("FAIL async_reset: req/idle/ready=%b required 011", {data_req, st_idle, st_ready});
    end
    tick();
    resetn = 1'b1;
    tick();
    data_data_ok = 1'b1;
    #1;
    n_tests++;
    if (st_done !== 1'b0) begin n_fail++; $display("FAIL stray_data_ok: st_done=%b required 0", st_done); end
    tick();
    data_data_ok = 1'b0;
    n_tests++;
    if (st_idle !== 1'b1) begin n_fail++; $display("FAIL stray_cnt: st_idle=%b required 1", st_idle); end
    issue_store(OP_SB, 32'h0000_9000, 32'h5A);
    pulse_addr_ok();
    data_data_ok = 1'b1;
    #1;
    n_tests++;
    if ({st_done, st_idle} !== 2'b10) begin n_fail++; $display("FAIL post_reset_done: done/idle=%b required 10", {st_done, st_idle}); end
    tick();
    data_data_ok = 1'b0;
    n_tests++;
    if (st_idle !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: st_idle=%b required 1", st_idle); end
  endtask

  initial begin
    resetn = 1'b0; st_valid = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    st_op = '0; st_addr = '0; st_data = '0;
    test_reset();
    test_sb();
    test_swl_swr();
    test_sh_null();
    test_addr_wait();
    test_outstanding();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
